// File: rtl/s_spi_slave_ctrl_pkg.sv
// Shared definitions for the s_spi_slave_ctrl block.
// Holds the FSM state encoding, the default word width and the helper that
// picks which SCLK edge samples MOSI for a given CPOL/CPHA pair.
package s_spi_slave_ctrl_pkg;

  localparam int unsigned DefaultDataWidth = 8;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } s_spi_state_e;

  // Leading edge is rising for CPOL=0; CPHA=0 samples on the leading edge.
  // Both cases reduce to "sample on rising when CPOL equals CPHA".
  function automatic bit sample_on_rise(input bit cpol, input bit cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/s_spi_sync.sv
// Synchroniser and edge detector for the SPI pins.
// SCLK, MOSI and SS each pass through SYNC_STAGES flops, then one more flop
// stage produces edge pulses and a MOSI copy aligned with those pulses.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   sclk, mosi, ss      raw SPI pins
//   mosi_s              synchronised MOSI, aligned with the edge pulses
//   sclk_rise/sclk_fall single-cycle pulses on synchronised SCLK edges
//   ss_fall/ss_rise     single-cycle pulses on synchronised SS edges
module s_spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic ss,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic sclk_prev_q, ss_prev_q;
  logic mosi_q, sclk_rise_q, sclk_fall_q, ss_fall_q, ss_rise_q;

  // SS resets to 0 so a select already held low at reset release produces
  // no falling edge; the controller then waits for a fresh frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      mosi_q      <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
      ss_rise_q   <= ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;
      ss_fall_q   <= ~ss_sync_q[SYNC_STAGES-1] & ss_prev_q;
    end
  end

  assign mosi_s    = mosi_q;
  assign sclk_rise = sclk_rise_q;
  assign sclk_fall = sclk_fall_q;
  assign ss_fall   = ss_fall_q;
  assign ss_rise   = ss_rise_q;

endmodule

// File: rtl/s_spi_slave_ctrl.sv
// SPI slave controller running on the system clock.
// Oversamples SCLK/MOSI/SS, supports all CPOL/CPHA modes, configurable word
// width and multi-word bursts under one SS assertion. TX side has a one-word
// holding register; RX side presents each completed word with valid/ready.
// Build option: define S_SPI_OVERRUN_EN to drop words that arrive while
// rx_data is still unconsumed and raise the sticky overrun flag; otherwise
// the new word overwrites rx_data and overrun stays 0.
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   SCLK, MOSI, SS, MISO        SPI pins (SS active low, MISO Z when idle)
//   tx_data/tx_valid/tx_ready   next word to transmit
//   rx_data/rx_valid/rx_ready   last received word
//   busy                        frame in progress
//   overrun                     sticky receive-overrun flag
module s_spi_slave_ctrl
  import s_spi_slave_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  SS,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);
  localparam bit SampleOnRise = sample_on_rise(CPOL, CPHA);

  logic mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;

  s_spi_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk     (SCLK),
    .mosi     (MOSI),
    .ss       (SS),
    .mosi_s   (mosi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .ss_fall  (ss_fall),
    .ss_rise  (ss_rise)
  );

  s_spi_state_e          state_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_shift_q, tx_shift_q, hold_q, rx_data_q;
  logic                  hold_full_q, rx_valid_q, first_q;
`ifdef S_SPI_OVERRUN_EN
  logic                  overrun_q;
`endif

  logic                  sample_edge, shift_edge, tx_take, rx_take;
  logic [DATA_WIDTH-1:0] rx_word, fill_word;

  assign sample_edge = SampleOnRise ? sclk_rise : sclk_fall;
  assign shift_edge  = SampleOnRise ? sclk_fall : sclk_rise;
  assign tx_take     = tx_valid & ~hold_full_q;
  assign rx_take     = rx_valid_q & rx_ready;
  assign rx_word     = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  // Underrun sends zeros.
  assign fill_word   = hold_full_q ? hold_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      first_q     <= 1'b0;
`ifdef S_SPI_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      if (tx_take) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
      if (rx_take) begin
        rx_valid_q <= 1'b0;
`ifdef S_SPI_OVERRUN_EN
        overrun_q  <= 1'b0;
`endif
      end

      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_q     <= StActive;
            bit_cnt_q   <= '0;
            first_q     <= 1'b1;
            tx_shift_q  <= fill_word;
            // A word written this cycle into an empty holding register
            // stays there for the next word boundary.
            hold_full_q <= tx_take;
          end
        end
        StActive: begin
          if (ss_rise) begin
            // Partial words are abandoned.
            state_q   <= StIdle;
            bit_cnt_q <= '0;
          end else if (sample_edge) begin
            rx_shift_q <= rx_word;
            if (bit_cnt_q == LastBit) begin
              bit_cnt_q <= '0;
`ifdef S_SPI_OVERRUN_EN
              if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= rx_word;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
`else
              rx_data_q  <= rx_word;
              rx_valid_q <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end else if (shift_edge) begin
            first_q <= 1'b0;
            if (CPHA && first_q) begin
              // MSB is already on MISO from the frame-start load.
            end else if (bit_cnt_q == '0) begin
              tx_shift_q  <= fill_word;
              hold_full_q <= tx_take;
            end else begin
              tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q == StActive);
  assign MISO     = busy ? tx_shift_q[DATA_WIDTH-1] : 1'bz;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef S_SPI_OVERRUN_EN
  assign overrun  = overrun_q;
`else
  assign overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_s_spi_slave_ctrl.sv
// Bench for s_spi_slave_ctrl: four DW=8 instances (modes 0..3) and one
// DW=16 mode-0 instance. Received words are checked through a scoreboard
// queue; MISO words and status flags are checked inline.
module tb_s_spi_slave_ctrl;

  localparam int NDUT = 5;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  logic mosi;
  logic [NDUT-1:0] sclk, ss, tx_valid, rx_ready;
  logic [NDUT-1:0] tx_ready, rx_valid, busy, overrun;
  wire  [NDUT-1:0] miso;
  logic [15:0] tx_data;
  logic [7:0]  rx_data8 [4];
  logic [15:0] rx_data16;
  logic [15:0] rx_data_w [NDUT];

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rx_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    s_spi_slave_ctrl #(
      .DATA_WIDTH (8),
      .CPOL       (g >= 2),
      .CPHA       ((g % 2) == 1),
      .SYNC_STAGES(2)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .SCLK    (sclk[g]),
      .MOSI    (mosi),
      .SS      (ss[g]),
      .MISO    (miso[g]),
      .tx_data (tx_data[7:0]),
      .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]),
      .rx_data (rx_data8[g]),
      .rx_valid(rx_valid[g]),
      .rx_ready(rx_ready[g]),
      .busy    (busy[g]),
      .overrun (overrun[g])
    );
    assign rx_data_w[g] = {8'h00, rx_data8[g]};
  end

  s_spi_slave_ctrl #(
    .DATA_WIDTH (16),
    .CPOL       (1'b0),
    .CPHA       (1'b0),
    .SYNC_STAGES(2)
  ) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .SCLK    (sclk[4]),
    .MOSI    (mosi),
    .SS      (ss[4]),
    .MISO    (miso[4]),
    .tx_data (tx_data),
    .tx_valid(tx_valid[4]),
    .tx_ready(tx_ready[4]),
    .rx_data (rx_data16),
    .rx_valid(rx_valid[4]),
    .rx_ready(rx_ready[4]),
    .busy    (busy[4]),
    .overrun (overrun[4])
  );
  assign rx_data_w[4] = rx_data16;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted RX word must match the oldest expected entry.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rx_valid[d] && rx_ready[d]) begin
        if (rx_q.size() == 0) check_val("rx_unexpected", {16'(d), rx_data_w[d]}, 32'hFFFF_FFFF);
        else check_val("rx_word", {16'(d), rx_data_w[d]}, rx_q.pop_front());
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_push(input int d, input logic [15:0] w);
    tx_data     = w;
    tx_valid[d] = 1'b1;
    wait_clks(1);
    tx_valid[d] = 1'b0;
    check_val("tx_full", 32'(tx_ready[d]), 32'd0);
  endtask

  // Master side of nbits bits, MSB first, in the mode of instance d.
  task automatic spi_bits(input int d, input int nbits, input logic [15:0] mo,
                          output logic [15:0] mi);
    bit cpol, cpha;
    cpol = (d == 2) || (d == 3);
    cpha = (d == 1) || (d == 3);
    mi = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        wait_clks(HALF);
        mi[i] = miso[d];
        sclk[d] = ~cpol;
        wait_clks(HALF);
        sclk[d] = cpol;
      end else begin
        sclk[d] = ~cpol;
        mosi = mo[i];
        wait_clks(HALF);
        mi[i] = miso[d];
        sclk[d] = cpol;
        wait_clks(HALF);
      end
    end
  endtask

  task automatic run_frame(input int d, input int dw, input logic [15:0] mo,
                           input logic [15:0] miso_exp, input string tag);
    logic [15:0] mi;
    ss[d] = 1'b0;
    wait_clks(HALF);
    rx_q.push_back({16'(d), mo});
    spi_bits(d, dw, mo, mi);
    check_val({tag, "_miso"}, 32'(mi), 32'(miso_exp));
    wait_clks(HALF);
    ss[d] = 1'b1;
    wait_clks(2 * HALF);
    check_val({tag, "_tx_ready"}, 32'(tx_ready[d]), 32'd1);
  endtask

  logic [15:0] mi;
  logic [15:0] burst_mo [3];
  logic [15:0] burst_tx [3];
  logic [15:0] ovr_word;
  logic        ovr_flag;

  initial begin
    rst      = 1'b1;
    mosi     = 1'b0;
    sclk     = 5'b01100;
    ss       = '1;
    tx_valid = '0;
    rx_ready = '1;
    tx_data  = '0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(6);

    check_val("rst_tx_ready", 32'(tx_ready[0]), 32'd1);
    check_val("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
    check_val("rst_rx_data", 32'(rx_data_w[0]), 32'd0);
    check_val("rst_busy", 32'(busy[0]), 32'd0);
    check_val("rst_overrun", 32'(overrun[0]), 32'd0);

    // Mode 0 and the other three modes.
    tx_push(0, 16'h00A5);
    run_frame(0, 8, 16'h003C, 16'h00A5, "mode0");
    for (int d = 1; d < 4; d++) begin
      tx_push(d, 16'h005A);
      run_frame(d, 8, 16'h00C3, 16'h005A, "modeN");
    end

    // DW=16 burst, holding register refilled after each reload.
    burst_mo[0] = 16'h1234; burst_mo[1] = 16'hBEEF; burst_mo[2] = 16'h0001;
    burst_tx[0] = 16'hCAFE; burst_tx[1] = 16'h8001; burst_tx[2] = 16'h7E55;
    tx_push(4, burst_tx[0]);
    ss[4] = 1'b0;
    wait_clks(HALF);
    for (int w = 0; w < 3; w++) begin
      check_val("burst_tx_ready", 32'(tx_ready[4]), 32'd1);
      if (w < 2) tx_push(4, burst_tx[w + 1]);
      rx_q.push_back({16'd4, burst_mo[w]});
      spi_bits(4, 16, burst_mo[w], mi);
      check_val("burst_miso", 32'(mi), 32'(burst_tx[w]));
      wait_clks(6);
    end
    wait_clks(HALF);
    ss[4] = 1'b1;
    wait_clks(2 * HALF);

    // Underrun and abort after 5 bits, then a clean frame.
    ss[0] = 1'b0;
    wait_clks(HALF);
    spi_bits(0, 5, 16'h0016, mi);
    check_val("abort_miso", 32'(mi), 32'd0);
    wait_clks(HALF);
    ss[0] = 1'b1;
    wait_clks(2 * HALF);
    check_val("abort_no_rx", 32'(rx_valid[0]), 32'd0);
    run_frame(0, 8, 16'h0081, 16'h0000, "after_abort");

    // Two words with the consumer stalled.
    rx_ready[0] = 1'b0;
    ss[0] = 1'b0;
    wait_clks(HALF);
    spi_bits(0, 8, 16'h0011, mi);
    check_val("ovr_miso1", 32'(mi), 32'd0);
    spi_bits(0, 8, 16'h0022, mi);
    check_val("ovr_miso2", 32'(mi), 32'd0);
    wait_clks(HALF);
    ss[0] = 1'b1;
    wait_clks(2 * HALF);
`ifdef S_SPI_OVERRUN_EN
    ovr_word = 16'h0011;
    ovr_flag = 1'b1;
`else
    ovr_word = 16'h0022;
    ovr_flag = 1'b0;
`endif
    check_val("ovr_rx_valid", 32'(rx_valid[0]), 32'd1);
    check_val("ovr_rx_data", 32'(rx_data_w[0]), 32'(ovr_word));
    check_val("ovr_flag", 32'(overrun[0]), 32'(ovr_flag));
    rx_q.push_back({16'd0, ovr_word});
    rx_ready[0] = 1'b1;
    wait_clks(1);
    check_val("ovr_cleared", 32'(overrun[0]), 32'd0);
    check_val("ovr_rx_taken", 32'(rx_valid[0]), 32'd0);

    // Reset in the middle of a frame with the holding register full.
    tx_push(0, 16'h0096);
    ss[0] = 1'b0;
    wait_clks(HALF);
    tx_push(0, 16'h0055);
    spi_bits(0, 3, 16'h0005, mi);
    check_val("pre_rst_miso", 32'(mi), 32'h4);
    rst = 1'b1;
    wait_clks(2);
    check_val("mid_rst_busy", 32'(busy[0]), 32'd0);
    check_val("mid_rst_rx_valid", 32'(rx_valid[0]), 32'd0);
    check_val("mid_rst_rx_data", 32'(rx_data_w[0]), 32'd0);
    check_val("mid_rst_tx_ready", 32'(tx_ready[0]), 32'd1);
    check_val("mid_rst_overrun", 32'(overrun[0]), 32'd0);
    rst = 1'b0;
    wait_clks(12);
    check_val("rst_stay_idle", 32'(busy[0]), 32'd0);
    sclk[0] = 1'b0;
    ss[0] = 1'b1;
    wait_clks(2 * HALF);
    tx_push(0, 16'h003E);
    run_frame(0, 8, 16'h005D, 16'h003E, "post_rst");

    wait_clks(4);
    check_val("rx_pending", 32'(rx_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
